// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared op, FSM state and stack constants for the load/store unit
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_e;

    localparam logic [7:0] DEF_STACK_TOP    = 8'hFF;
    localparam logic [7:0] DEF_STACK_BOTTOM = 8'hC0;

endpackage

// File: rtl/stack_pointer.sv
// rtl/stack_pointer.sv - stack pointer register with full/empty detection (LSU_STACK_GUARD_EN)
module stack_pointer
    import cpu_pkg::*;
#(
    parameter logic [7:0] STACK_TOP    = DEF_STACK_TOP,
    parameter logic [7:0] STACK_BOTTOM = DEF_STACK_BOTTOM
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] sp,
    output logic [7:0] sp_plus1,
    output logic       full,
    output logic       empty
);

`ifdef LSU_STACK_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic [7:0] sp_q, sp_d;

    always_comb begin
        sp_d = sp_q;
        if (inc) begin
            sp_d = sp_q + 8'd1;
        end else if (dec) begin
            sp_d = sp_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= STACK_TOP;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Without the guard both flags stay low, so the stack wraps modulo 256.
    assign sp       = sp_q;
    assign sp_plus1 = sp_q + 8'd1;
    assign full     = GUARD_EN && (sp_q == STACK_BOTTOM - 8'd1);
    assign empty    = GUARD_EN && (sp_q == STACK_TOP);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - core LOAD/STORE/PUSH/POP to data memory; stack guard via LSU_STACK_GUARD_EN
module load_store_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] STACK_TOP    = DEF_STACK_TOP,
    parameter logic [7:0] STACK_BOTTOM = DEF_STACK_BOTTOM
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_fault,
    output logic [7:0] sp,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    lsu_state_e state_q, state_d;
    op_e        op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       fault_q, fault_d;

    logic [7:0] sp_plus1;
    logic       sp_full, sp_empty;
    logic       sp_inc, sp_dec;
    logic       fault;
    logic       is_write;
    logic [7:0] eff_addr;

    stack_pointer #(
        .STACK_TOP   (STACK_TOP),
        .STACK_BOTTOM(STACK_BOTTOM)
    ) u_stack_pointer (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (sp_inc),
        .dec     (sp_dec),
        .sp      (sp),
        .sp_plus1(sp_plus1),
        .full    (sp_full),
        .empty   (sp_empty)
    );

    assign fault    = ((op_q == OP_PUSH) && sp_full) || ((op_q == OP_POP) && sp_empty);
    assign is_write = (op_q == OP_STORE) || (op_q == OP_PUSH);

    always_comb begin
        case (op_q)
            OP_PUSH: eff_addr = sp;
            OP_POP:  eff_addr = sp_plus1;
            default: eff_addr = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            op_q    <= OP_LOAD;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:   if (req_valid) state_d = LSU_ACCESS;
            LSU_ACCESS: state_d = LSU_RESP;
            LSU_RESP:   if (rsp_ready) state_d = LSU_IDLE;
            default:    state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == LSU_IDLE);
        rsp_valid = (state_q == LSU_RESP);
        mem_we    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        if (state_q == LSU_ACCESS) begin
            mem_we    = is_write && !fault;
            mem_addr  = eff_addr;
            mem_wdata = wdata_q;
            sp_dec    = (op_q == OP_PUSH) && !fault;
            sp_inc    = (op_q == OP_POP) && !fault;
        end
    end

    // Request fields are only sampled at the IDLE handshake; the response is captured in ACCESS.
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        if (state_q == LSU_IDLE && req_valid) begin
            op_d    = op_e'(req_op);
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
        if (state_q == LSU_ACCESS) begin
            fault_d = fault;
            rdata_d = ((op_q == OP_LOAD || op_q == OP_POP) && !fault) ? mem_rdata : 8'h00;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule
